seg7_scan_monitor: RTL and testbench

Receiving end of the 7-segment display path: observes the multiplexed segment bus (common-cathode, {g,f,e,d,c,b,a}, 1 = on) and its one-hot digit enables, filters each pattern for stability, and decodes it back into the 4-bit display code per digit. It sits beside the display driver in self-checking builds, so on-chip logic and the bench can read what is actually being shown, including the PASS/FAIL characters.

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/seg7_scan_monitor_pattern_decode.sv | 40 ++++
 rtl/seg7_scan_monitor.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan monitor.
// Segment patterns are {g,f,e,d,c,b,a}, common-cathode, 1 = segment lit.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_L     = 7'b0111000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  // 'S' is indistinguishable from '5' on the bus; it always decodes as 5.
  localparam logic [6:0] SEG_S     = SEG_5;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_0    = 4'h0;
  localparam logic [3:0] CODE_1    = 4'h1;
  localparam logic [3:0] CODE_2    = 4'h2;
  localparam logic [3:0] CODE_3    = 4'h3;
  localparam logic [3:0] CODE_4    = 4'h4;
  localparam logic [3:0] CODE_5    = 4'h5;
  localparam logic [3:0] CODE_6    = 4'h6;
  localparam logic [3:0] CODE_7    = 4'h7;
  localparam logic [3:0] CODE_8    = 4'h8;
  localparam logic [3:0] CODE_9    = 4'h9;
  localparam logic [3:0] CODE_A    = 4'hA;
  localparam logic [3:0] CODE_P    = 4'hB;
  localparam logic [3:0] CODE_S    = 4'hC;
  localparam logic [3:0] CODE_F    = 4'hD;
  localparam logic [3:0] CODE_L    = 4'hE;
  localparam logic [3:0] CODE_DASH = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } mon_state_t;

endpackage

// File: rtl/seg7_scan_monitor_pattern_decode.sv
// Combinational decode of a 7-segment pattern back to its display code.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       known,
  output logic       blank
);

  // Map each recognised pattern to its code; blank and unknown give code 0.
  always_comb begin
    code  = CODE_0;
    known = 1'b1;
    blank = 1'b0;
    case (pattern)
      SEG_0:     code = CODE_0;
      SEG_1:     code = CODE_1;
      SEG_2:     code = CODE_2;
      SEG_3:     code = CODE_3;
      SEG_4:     code = CODE_4;
      SEG_5:     code = CODE_5;
      SEG_6:     code = CODE_6;
      SEG_7:     code = CODE_7;
      SEG_8:     code = CODE_8;
      SEG_9:     code = CODE_9;
      SEG_A:     code = CODE_A;
      SEG_P:     code = CODE_P;
      SEG_F:     code = CODE_F;
      SEG_L:     code = CODE_L;
      SEG_DASH:  code = CODE_DASH;
      SEG_BLANK: begin
        known = 1'b0;
        blank = 1'b1;
      end
      default:   known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_monitor.sv
// Observes a multiplexed 7-segment bus, filters each pattern for stability
// and decodes it back to a per-digit display code.
// Optional feature macro: SEG7_MON_PASSFAIL_EN adds pass_seen / fail_seen.
module seg7_scan_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digit_code,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd_stb,
  output logic [IDX_W-1:0]        upd_idx,
  output logic                    err_pattern,
  output logic                    err_onehot
`ifdef SEG7_MON_PASSFAIL_EN
  ,
  output logic                    pass_seen,
  output logic                    fail_seen
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] dig_q;
  logic [CNT_W-1:0]      cnt;
  mon_state_t            state;

  logic                  sample_same;
  logic                  commit;
  logic                  en_onehot;
  logic [IDX_W-1:0]      en_idx;
  logic [3:0]            dec_code;
  logic                  dec_known;
  logic                  dec_blank;

  seg7_pattern_decode u_decode (
    .pattern (seg_q),
    .code    (dec_code),
    .known   (dec_known),
    .blank   (dec_blank)
  );

  // Stability and one-hot qualification of the currently held sample.
  always_comb begin
    sample_same = (seg_in == seg_q) && (dig_en == dig_q);
    commit      = sample_same && (state == SETTLE) && (cnt == CNT_MAX);
    en_onehot   = (dig_q != '0) &&
                  ((dig_q & (dig_q - NUM_DIGITS'(1))) == '0);
    en_idx      = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q[i]) en_idx = IDX_W'(i);
    end
  end

  // Sampling, stability FSM and all committed outputs.
  // The commit fires on the edge that would otherwise only confirm the
  // counter is saturated, so the held sample in seg_q/dig_q is what gets
  // decoded; clear overrides the output update but never the FSM/counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= '0;
      dig_q       <= '0;
      cnt         <= '0;
      state       <= IDLE;
      digit_code  <= '0;
      digit_valid <= '0;
      upd_stb     <= 1'b0;
      upd_idx     <= '0;
      err_pattern <= 1'b0;
      err_onehot  <= 1'b0;
    end else begin
      seg_q   <= seg_in;
      dig_q   <= dig_en;
      upd_stb <= 1'b0;

      if (!sample_same) begin
        cnt   <= '0;
        state <= (dig_en == '0) ? IDLE : SETTLE;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (commit) state <= HELD;
      end

      if (clear) begin
        digit_code  <= '0;
        digit_valid <= '0;
        err_pattern <= 1'b0;
        err_onehot  <= 1'b0;
      end else if (commit) begin
        if (!en_onehot) begin
          err_onehot <= 1'b1;
        end else if (dec_known || dec_blank) begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (dig_q[i]) begin
              digit_code[4*i +: 4] <= dec_code;
              digit_valid[i]       <= dec_known;
            end
          end
          upd_stb <= 1'b1;
          upd_idx <= en_idx;
        end else begin
          err_pattern <= 1'b1;
        end
      end
    end
  end

`ifdef SEG7_MON_PASSFAIL_EN
  logic pass_match;
  logic fail_match;

  // Digits 3..0 spelling "PASS" or "FAIL" (I shown as 1).
  always_comb begin
    pass_match = (&digit_valid[3:0]) &&
                 (digit_code[15:0] == {CODE_P, CODE_A, CODE_5, CODE_5});
    fail_match = (&digit_valid[3:0]) &&
                 (digit_code[15:0] == {CODE_F, CODE_A, CODE_1, CODE_L});
  end

  // Sticky result flags, one cycle behind the captured digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_seen <= 1'b0;
      fail_seen <= 1'b0;
    end else if (clear) begin
      pass_seen <= 1'b0;
      fail_seen <= 1'b0;
    end else begin
      if (pass_match) pass_seen <= 1'b1;
      if (fail_match) fail_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Self-checking bench for seg7_scan_monitor (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg7_scan_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_en = '0;
  logic        clear = 1'b0;
  logic [15:0] digit_code;
  logic [3:0]  digit_valid;
  logic        upd_stb;
  logic [1:0]  upd_idx;
  logic        err_pattern;
  logic        err_onehot;
`ifdef SEG7_MON_PASSFAIL_EN
  logic        pass_seen;
  logic        fail_seen;
`endif

  always #5 clk = ~clk;

  seg7_scan_monitor #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
`ifdef SEG7_MON_PASSFAIL_EN
    .pass_seen   (pass_seen),
    .fail_seen   (fail_seen),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .clear       (clear),
    .digit_code  (digit_code),
    .digit_valid (digit_valid),
    .upd_stb     (upd_stb),
    .upd_idx     (upd_idx),
    .err_pattern (err_pattern),
    .err_onehot  (err_onehot)
  );

  typedef struct {
    logic [1:0] idx;
    logic [3:0] code;
    logic       valid;
  } stb_t;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] en;
    int         dwell;
    bit         stb;
    logic [1:0] idx;
    logic [3:0] code;
    bit         valid;
    bit         errp;
    bit         erro;
  } row_t;

  stb_t       exp_q[$];
  row_t       rows[18];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] exp_code[4];
  logic       exp_valid[4];
  logic [1:0] exp_idx = '0;
  logic       exp_errp = 1'b0;
  logic       exp_erro = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic row_t mk(input logic [6:0] seg, input logic [3:0] en, input int dwell,
                              input bit stb, input logic [1:0] idx, input logic [3:0] code,
                              input bit valid, input bit errp, input bit erro);
    row_t r;
    r.seg = seg; r.en = en; r.dwell = dwell; r.stb = stb; r.idx = idx;
    r.code = code; r.valid = valid; r.errp = errp; r.erro = erro;
    return r;
  endfunction

  function automatic logic [15:0] exp_code_vec();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = exp_code[i];
    return v;
  endfunction

  function automatic logic [3:0] exp_valid_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = exp_valid[i];
    return v;
  endfunction

  task automatic zero_expect();
    for (int i = 0; i < 4; i++) begin
      exp_code[i]  = '0;
      exp_valid[i] = 1'b0;
    end
    exp_errp = 1'b0;
    exp_erro = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_code"}, digit_code, exp_code_vec());
    check({tag, "_valid"}, digit_valid, exp_valid_vec());
    check({tag, "_errp"}, err_pattern, exp_errp);
    check({tag, "_erro"}, err_onehot, exp_erro);
    check({tag, "_idx"}, upd_idx, exp_idx);
    check({tag, "_stb_low"}, upd_stb, 1'b0);
  endtask

  task automatic expect_stb(input logic [1:0] idx, input logic [3:0] code, input logic valid);
    stb_t s;
    s.idx = idx; s.code = code; s.valid = valid;
    exp_q.push_back(s);
    exp_code[idx]  = code;
    exp_valid[idx] = valid;
    exp_idx        = idx;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      seg_in = rows[i].seg;
      dig_en = rows[i].en;
      if (rows[i].stb) expect_stb(rows[i].idx, rows[i].code, rows[i].valid);
      exp_errp = rows[i].errp;
      exp_erro = rows[i].erro;
      repeat (rows[i].dwell) @(posedge clk);
      #1;
      check_state($sformatf("row%0d", i));
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    zero_expect();
    check_state("clear");
  endtask

  // Scoreboard: each strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && upd_stb) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", upd_stb, 1'b0);
      end else begin
        stb_t s;
        s = exp_q.pop_front();
        check("stb_idx", upd_idx, s.idx);
        check("stb_code", digit_code[{upd_idx, 2'b00} +: 4], s.code);
        check("stb_valid", digit_valid[upd_idx], s.valid);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rows[0]  = mk(7'b1111111, 4'b0100, 3, 0, 2'd0, 4'h0, 0, 0, 0);
    rows[1]  = mk(7'b0000110, 4'b0100, 6, 1, 2'd2, 4'h1, 1, 0, 0);
    rows[2]  = mk(7'b1010101, 4'b0010, 6, 0, 2'd0, 4'h0, 0, 1, 0);
    rows[3]  = mk(7'b0111111, 4'b0011, 6, 0, 2'd0, 4'h0, 0, 0, 1);
    rows[4]  = mk(7'b0111111, 4'b0000, 8, 0, 2'd0, 4'h0, 0, 0, 1);
    rows[5]  = mk(7'b0111111, 4'b1000, 6, 1, 2'd3, 4'h0, 1, 0, 0);
    rows[6]  = mk(7'b0000000, 4'b1000, 6, 1, 2'd3, 4'h0, 0, 0, 0);
    rows[7]  = mk(7'b1010101, 4'b0100, 3, 0, 2'd0, 4'h0, 0, 0, 0);
    rows[8]  = mk(7'b1000000, 4'b0100, 6, 1, 2'd2, 4'hF, 1, 0, 0);
    rows[9]  = mk(7'b1111101, 4'b0001, 6, 1, 2'd0, 4'h6, 1, 0, 0);
    rows[10] = mk(7'b1110011, 4'b1000, 6, 1, 2'd3, 4'hB, 1, 0, 0);
    rows[11] = mk(7'b1110111, 4'b0100, 6, 1, 2'd2, 4'hA, 1, 0, 0);
    rows[12] = mk(7'b1101101, 4'b0010, 6, 1, 2'd1, 4'h5, 1, 0, 0);
    rows[13] = mk(7'b1101101, 4'b0001, 6, 1, 2'd0, 4'h5, 1, 0, 0);
    rows[14] = mk(7'b1110001, 4'b1000, 6, 1, 2'd3, 4'hD, 1, 0, 0);
    rows[15] = mk(7'b1110111, 4'b0100, 6, 1, 2'd2, 4'hA, 1, 0, 0);
    rows[16] = mk(7'b0000110, 4'b0010, 6, 1, 2'd1, 4'h1, 1, 0, 0);
    rows[17] = mk(7'b0111000, 4'b0001, 6, 1, 2'd0, 4'hE, 1, 0, 0);

    zero_expect();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_state("reset");
`ifdef SEG7_MON_PASSFAIL_EN
    check("reset_pass", pass_seen, 1'b0);
    check("reset_fail", fail_seen, 1'b0);
`endif

    // First commit: strobe must appear only after the fifth edge.
    seg_in = 7'b1011011;
    dig_en = 4'b0001;
    expect_stb(2'd0, 4'h2, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_edge%0d_stb", e), upd_stb, 1'b0);
    end
    @(posedge clk);
    #1;
    check("lat_edge5_stb", upd_stb, 1'b1);
    check("lat_edge5_idx", upd_idx, 2'd0);
    @(posedge clk);
    #1;
    check_state("lat_after");

    apply_rows(0, 2);
    pulse_clear();
    apply_rows(3, 4);
    pulse_clear();
    apply_rows(5, 13);
`ifdef SEG7_MON_PASSFAIL_EN
    check("pass_seen_set", pass_seen, 1'b1);
    check("fail_seen_clr", fail_seen, 1'b0);
`endif
    apply_rows(14, 17);
`ifdef SEG7_MON_PASSFAIL_EN
    check("pass_seen_sticky", pass_seen, 1'b1);
    check("fail_seen_set", fail_seen, 1'b1);
`endif

    // Reset in the middle of digit 1 settling.
    seg_in = 7'b0000110;
    dig_en = 4'b0010;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    zero_expect();
    exp_idx = '0;
    check_state("midreset");
`ifdef SEG7_MON_PASSFAIL_EN
    check("midreset_pass", pass_seen, 1'b0);
    check("midreset_fail", fail_seen, 1'b0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_stb(2'd1, 4'h1, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_edge%0d_stb", e), upd_stb, 1'b0);
    end
    @(posedge clk);
    #1;
    check("rst_edge5_stb", upd_stb, 1'b1);
    @(posedge clk);
    #1;
    check_state("postreset");

    // Clear on the very edge that would commit: clear wins, no strobe.
    seg_in = 7'b0111111;
    dig_en = 4'b0001;
    repeat (4) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clrcommit_stb", upd_stb, 1'b0);
    zero_expect();
    repeat (3) @(posedge clk);
    #1;
    check_state("clrcommit");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
